// File: rtl/apb_acc_stream.sv
// rtl/apb_acc_stream.sv - APB register front end feeding samples to an accelerator core and collecting its results
`timescale 1ns/1ps
module apb_acc_stream #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int IN_DEPTH       = 8,
  parameter int OUT_DEPTH      = 8
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [31:0]               PWDATA,
  input  logic                      PWRITE,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  output logic [31:0]               PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR,
  output logic                      acc_valid_o,
  output logic [DATA_WIDTH-1:0]     acc_data_o,
  input  logic                      acc_ready_i,
  input  logic                      res_valid_i,
  input  logic [DATA_WIDTH-1:0]     res_data_i,
  output logic                      res_ready_o,
  output logic                      irq_o
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);

  localparam logic [3:0] REG_CTRL     = 4'h0;
  localparam logic [3:0] REG_DATA_IN  = 4'h1;
  localparam logic [3:0] REG_DATA_OUT = 4'h2;
  localparam logic [3:0] REG_STATUS   = 4'h3;
  localparam logic [3:0] REG_IN_CNT   = 4'h4;
  localparam logic [3:0] REG_OUT_CNT  = 4'h5;

  // Register state
  logic                  enable_q, enable_d;
  logic                  irq_en_q, irq_en_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [31:0]           in_count_q, in_count_d;
  logic [31:0]           out_count_q, out_count_d;

  // FIFO pointers and occupancy
  logic [IN_AW-1:0]      in_wr_q, in_wr_d, in_rd_q, in_rd_d;
  logic [IN_AW:0]        in_occ_q, in_occ_d;
  logic [OUT_AW-1:0]     out_wr_q, out_wr_d, out_rd_q, out_rd_d;
  logic [OUT_AW:0]       out_occ_q, out_occ_d;

  logic [DATA_WIDTH-1:0] in_mem_q  [IN_DEPTH];
  logic [DATA_WIDTH-1:0] out_mem_q [OUT_DEPTH];

  // Decode and handshake signals
  logic                  access, wr_acc, rd_acc;
  logic [3:0]            offs;
  logic                  in_push, out_pop, core_pop, res_push;
  logic                  set_ovf, set_udf, ctrl_wr, status_wr, clear;
  logic                  in_full, in_empty, out_full, out_empty;
  logic [31:0]           status_word, head_word;
  logic                  unused_paddr;

  assign unused_paddr = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};

  // An access in reset is ignored so nothing (including PSLVERR) leaks out
  assign access = PSEL & PENABLE & HRESETn;
  assign wr_acc = access & PWRITE;
  assign rd_acc = access & ~PWRITE;
  assign offs   = PADDR[5:2];

  // Occupancy never exceeds depth, so the MSB alone marks full
  assign in_full   = in_occ_q[IN_AW];
  assign in_empty  = (in_occ_q == '0);
  assign out_full  = out_occ_q[OUT_AW];
  assign out_empty = (out_occ_q == '0);

  assign PREADY      = 1'b1;
  assign acc_valid_o = enable_q & ~in_empty;
  assign acc_data_o  = in_mem_q[in_rd_q];
  assign res_ready_o = ~out_full;
  assign irq_o       = irq_en_q & ~out_empty;
  assign core_pop    = acc_valid_o & acc_ready_i;
  assign res_push    = res_valid_i & res_ready_o;

  // Status word and zero-extended output FIFO head
  always_comb begin
    status_word        = '0;
    status_word[0]     = in_full;
    status_word[1]     = in_empty;
    status_word[2]     = out_full;
    status_word[3]     = out_empty;
    status_word[4]     = ovf_q;
    status_word[5]     = udf_q;
    status_word[15:8]  = 8'(in_occ_q);
    status_word[23:16] = 8'(out_occ_q);
    head_word                   = '0;
    head_word[DATA_WIDTH-1:0]   = out_mem_q[out_rd_q];
  end

  // APB register decode: read data, error response and side-effect strobes
  always_comb begin
    PRDATA    = '0;
    PSLVERR   = 1'b0;
    in_push   = 1'b0;
    out_pop   = 1'b0;
    set_ovf   = 1'b0;
    set_udf   = 1'b0;
    ctrl_wr   = 1'b0;
    status_wr = 1'b0;
    if (access) begin
      case (offs)
        REG_CTRL: begin
          if (wr_acc) ctrl_wr = 1'b1;
          else        PRDATA  = {29'd0, irq_en_q, 1'b0, enable_q};
        end
        REG_DATA_IN: begin
          if (wr_acc) begin
            if (in_full) begin
              PSLVERR = 1'b1;
              set_ovf = 1'b1;
            end else begin
              in_push = 1'b1;
            end
          end
        end
        REG_DATA_OUT: begin
          if (wr_acc) begin
            PSLVERR = 1'b1;
          end else if (out_empty) begin
            PSLVERR = 1'b1;
            set_udf = 1'b1;
          end else begin
            PRDATA  = head_word;
            out_pop = 1'b1;
          end
        end
        REG_STATUS: begin
          if (wr_acc) status_wr = 1'b1;
          else        PRDATA    = status_word;
        end
        REG_IN_CNT: begin
          if (wr_acc) PSLVERR = 1'b1;
          else        PRDATA  = in_count_q;
        end
        REG_OUT_CNT: begin
          if (wr_acc) PSLVERR = 1'b1;
          else        PRDATA  = out_count_q;
        end
        default: PSLVERR = 1'b1;
      endcase
    end
  end

  // The clear bit of a CTRL write is the one-cycle flush pulse
  assign clear = ctrl_wr & PWDATA[1];

  // Next-state for pointers, occupancy, counters and flags; clear wins over all traffic
  always_comb begin
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    in_count_d  = in_count_q;
    out_count_d = out_count_q;
    in_wr_d     = in_wr_q;
    in_rd_d     = in_rd_q;
    in_occ_d    = in_occ_q;
    out_wr_d    = out_wr_q;
    out_rd_d    = out_rd_q;
    out_occ_d   = out_occ_q;

    if (in_push)  in_wr_d  = in_wr_q + 1'b1;
    if (core_pop) in_rd_d  = in_rd_q + 1'b1;
    case ({in_push, core_pop})
      2'b10:   in_occ_d = in_occ_q + 1'b1;
      2'b01:   in_occ_d = in_occ_q - 1'b1;
      default: in_occ_d = in_occ_q;
    endcase

    if (res_push) out_wr_d = out_wr_q + 1'b1;
    if (out_pop)  out_rd_d = out_rd_q + 1'b1;
    case ({res_push, out_pop})
      2'b10:   out_occ_d = out_occ_q + 1'b1;
      2'b01:   out_occ_d = out_occ_q - 1'b1;
      default: out_occ_d = out_occ_q;
    endcase

    if (in_push) in_count_d  = in_count_q + 32'd1;
    if (out_pop) out_count_d = out_count_q + 32'd1;

    if (set_ovf) ovf_d = 1'b1;
    if (set_udf) udf_d = 1'b1;
    if (status_wr) begin
      if (PWDATA[4]) ovf_d = 1'b0;
      if (PWDATA[5]) udf_d = 1'b0;
    end

    if (ctrl_wr) begin
      enable_d = PWDATA[0];
      irq_en_d = PWDATA[2];
    end

    if (clear) begin
      ovf_d       = 1'b0;
      udf_d       = 1'b0;
      in_count_d  = '0;
      out_count_d = '0;
      in_wr_d     = '0;
      in_rd_d     = '0;
      in_occ_d    = '0;
      out_wr_d    = '0;
      out_rd_d    = '0;
      out_occ_d   = '0;
    end
  end

  // Control/status registers with asynchronous reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable_q    <= 1'b0;
      irq_en_q    <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      in_count_q  <= '0;
      out_count_q <= '0;
      in_wr_q     <= '0;
      in_rd_q     <= '0;
      in_occ_q    <= '0;
      out_wr_q    <= '0;
      out_rd_q    <= '0;
      out_occ_q   <= '0;
    end else begin
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      in_count_q  <= in_count_d;
      out_count_q <= out_count_d;
      in_wr_q     <= in_wr_d;
      in_rd_q     <= in_rd_d;
      in_occ_q    <= in_occ_d;
      out_wr_q    <= out_wr_d;
      out_rd_q    <= out_rd_d;
      out_occ_q   <= out_occ_d;
    end
  end

  // FIFO storage needs no reset; validity comes from occupancy
  always_ff @(posedge HCLK) begin
    if (in_push)  in_mem_q[in_wr_q]   <= PWDATA[DATA_WIDTH-1:0];
    if (res_push) out_mem_q[out_wr_q] <= res_data_i;
  end

endmodule

// File: tb/tb_apb_acc_stream.sv
// tb/tb_apb_acc_stream.sv - directed bench for apb_acc_stream
`timescale 1ns/1ps
module tb_apb_acc_stream;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic        acc_valid_o, acc_ready_i;
  logic [31:0] acc_data_o;
  logic        res_valid_i, res_ready_o;
  logic [31:0] res_data_i;
  logic        irq_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  apb_acc_stream dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PWRITE      (PWRITE),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .acc_valid_o (acc_valid_o),
    .acc_data_o  (acc_data_o),
    .acc_ready_i (acc_ready_i),
    .res_valid_i (res_valid_i),
    .res_data_i  (res_data_i),
    .res_ready_o (res_ready_o),
    .irq_o       (irq_o)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Setup phase then access phase; samples the response mid access cycle
  task automatic apb_begin(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    #3;
    rdata = PRDATA;
    err   = PSLVERR;
  endtask

  task automatic apb_end();
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    apb_begin(wr, addr, wdata, rdata, err);
    apb_end();
  endtask

  task automatic apb_rd_chk(input string name, input logic [11:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, addr, 32'h0, rd, er);
    chk(name, rd, exp);
  endtask

  task automatic apb_wr(input logic [11:0] addr, input logic [31:0] wdata, output logic err);
    logic [31:0] rd;
    apb(1'b1, addr, wdata, rd, err);
  endtask

  task automatic core_push(input logic [31:0] data);
    res_valid_i = 1'b1; res_data_i = data;
    @(posedge HCLK); #1;
    res_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    HRESETn = 1'b0; PADDR = 12'h03C; PWDATA = '0; PWRITE = 1'b0;
    PSEL = 1'b1; PENABLE = 1'b1;
    acc_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0;

    // Outputs held in reset, even with an unmapped access pending
    #12;
    chk("rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("rst_pready", {31'd0, PREADY}, 32'd1);
    chk("rst_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    chk("rst_res_ready", {31'd0, res_ready_o}, 32'd1);
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    apb_rd_chk("rst_status", 12'h00C, 32'h0000_000A);

    // Register map vectors: enable=0, core idle
    add_vec(0, 12'h000, 32'h0,         32'h0,         0);
    add_vec(1, 12'h000, 32'h4,         32'h0,         0);
    add_vec(0, 12'h000, 32'h0,         32'h4,         0);
    add_vec(1, 12'h000, 32'hFFFF_FFF8, 32'h0,         0);
    add_vec(0, 12'h000, 32'h0,         32'h0,         0);
    add_vec(1, 12'h004, 32'h11,        32'h0,         0);
    add_vec(1, 12'h004, 32'h22,        32'h0,         0);
    add_vec(0, 12'h00C, 32'h0,         32'h0000_0208, 0);
    add_vec(0, 12'h40C, 32'h0,         32'h0000_0208, 0);
    add_vec(0, 12'h010, 32'h0,         32'h2,         0);
    add_vec(1, 12'h010, 32'h5,         32'h0,         1);
    add_vec(0, 12'h010, 32'h0,         32'h2,         0);
    add_vec(1, 12'h018, 32'h1,         32'h0,         1);
    add_vec(0, 12'h018, 32'h0,         32'h0,         1);
    add_vec(0, 12'h03C, 32'h0,         32'h0,         1);
    add_vec(1, 12'h008, 32'h1,         32'h0,         1);
    add_vec(0, 12'h008, 32'h0,         32'h0,         1);
    add_vec(0, 12'h00C, 32'h0,         32'h0000_0228, 0);
    add_vec(0, 12'h014, 32'h0,         32'h0,         0);
    add_vec(1, 12'h00C, 32'h20,        32'h0,         0);
    add_vec(0, 12'h00C, 32'h0,         32'h0000_0208, 0);
    add_vec(0, 12'h004, 32'h0,         32'h0,         0);
    add_vec(1, 12'h014, 32'h1,         32'h0,         1);

    for (int i = 0; i < vecs.size(); i++) begin
      apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, er);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
      if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end

    // Feeding the core only once enabled, in order
    chk("idle_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    acc_ready_i = 1'b1;
    apb_wr(12'h000, 32'h1, er);
    chk("feed0_valid", {31'd0, acc_valid_o}, 32'd1);
    chk("feed0_data", acc_data_o, 32'h11);
    @(posedge HCLK); #1;
    chk("feed1_valid", {31'd0, acc_valid_o}, 32'd1);
    chk("feed1_data", acc_data_o, 32'h22);
    @(posedge HCLK); #1;
    chk("feed_done_valid", {31'd0, acc_valid_o}, 32'd0);
    acc_ready_i = 1'b0;
    apb_rd_chk("feed_in_cnt", 12'h010, 32'd2);
    apb_rd_chk("feed_status", 12'h00C, 32'h0000_000A);

    // Input overflow on the ninth write, then W1C of ovf
    apb_wr(12'h000, 32'h0, er);
    for (int i = 0; i < 9; i++) begin
      apb_wr(12'h004, 32'hA0 + i, er);
      chk($sformatf("fill%0d_err", i), {31'd0, er}, (i == 8) ? 32'd1 : 32'd0);
    end
    apb_rd_chk("ovf_status", 12'h00C, 32'h0000_0819);
    apb_rd_chk("ovf_in_cnt", 12'h010, 32'd10);
    apb_wr(12'h00C, 32'h10, er);
    apb_rd_chk("ovf_w1c_status", 12'h00C, 32'h0000_0809);

    // Push while full is rejected even though the core pops that cycle
    apb_wr(12'h000, 32'h1, er);
    apb_begin(1'b1, 12'h004, 32'hEE, rd, er);
    acc_ready_i = 1'b1;
    apb_end();
    acc_ready_i = 1'b0;
    chk("full_pop_err", {31'd0, er}, 32'd1);
    chk("full_pop_head", acc_data_o, 32'hA1);
    apb_rd_chk("full_pop_status", 12'h00C, 32'h0000_0718);
    apb_rd_chk("full_pop_in_cnt", 12'h010, 32'd10);
    apb_wr(12'h000, 32'h2, er);
    apb_rd_chk("clr1_status", 12'h00C, 32'h0000_000A);
    apb_rd_chk("clr1_in_cnt", 12'h010, 32'd0);

    // Output FIFO fills from the core; extra result is refused
    res_valid_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      res_data_i = (i == 8) ? 32'h999 : 32'h100 + i;
      @(posedge HCLK); #1;
    end
    res_valid_i = 1'b0;
    chk("out_full_ready", {31'd0, res_ready_o}, 32'd0);
    apb_rd_chk("out_full_status", 12'h00C, 32'h0008_0006);
    chk("irq_off", {31'd0, irq_o}, 32'd0);
    apb_wr(12'h000, 32'h4, er);
    chk("irq_on", {31'd0, irq_o}, 32'd1);
    apb(1'b0, 12'h008, 32'h0, rd, er);
    chk("pop0_data", rd, 32'h100);
    chk("pop0_err", {31'd0, er}, 32'd0);
    chk("pop0_ready", {31'd0, res_ready_o}, 32'd1);
    apb_rd_chk("pop0_out_cnt", 12'h014, 32'd1);

    // Drain to three, then a simultaneous core push and APB pop
    for (int i = 1; i < 5; i++) apb_rd_chk($sformatf("drain%0d", i), 12'h008, 32'h100 + i);
    apb_rd_chk("three_status", 12'h00C, 32'h0003_0002);
    apb_begin(1'b0, 12'h008, 32'h0, rd, er);
    res_valid_i = 1'b1; res_data_i = 32'h200;
    apb_end();
    res_valid_i = 1'b0;
    chk("simul_data", rd, 32'h105);
    apb_rd_chk("simul_status", 12'h00C, 32'h0003_0002);
    apb_rd_chk("order0", 12'h008, 32'h106);
    apb_rd_chk("order1", 12'h008, 32'h107);
    apb_rd_chk("order2", 12'h008, 32'h200);
    chk("irq_empty", {31'd0, irq_o}, 32'd0);
    apb_rd_chk("order_out_cnt", 12'h014, 32'd9);

    // Clear with both FIFOs holding data and ovf set; enable survives
    apb_wr(12'h000, 32'h0, er);
    for (int i = 0; i < 9; i++) apb_wr(12'h004, 32'h40 + i, er);
    core_push(32'h55);
    apb_rd_chk("pre_clr_status", 12'h00C, 32'h0001_0811);
    apb_wr(12'h000, 32'h3, er);
    apb_rd_chk("clr_status", 12'h00C, 32'h0000_000A);
    apb_rd_chk("clr_in_cnt", 12'h010, 32'd0);
    apb_rd_chk("clr_out_cnt", 12'h014, 32'd0);
    apb_rd_chk("clr_ctrl", 12'h000, 32'h1);
    chk("clr_acc_valid", {31'd0, acc_valid_o}, 32'd0);

    // Reset landing in the middle of an access phase
    core_push(32'h77);
    apb_wr(12'h000, 32'h5, er);
    apb_wr(12'h004, 32'h33, er);
    chk("pre_rst_irq", {31'd0, irq_o}, 32'd1);
    chk("pre_rst_valid", {31'd0, acc_valid_o}, 32'd1);
    apb_begin(1'b0, 12'h03C, 32'h0, rd, er);
    HRESETn = 1'b0;
    #1;
    chk("mid_rst_pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("mid_rst_pready", {31'd0, PREADY}, 32'd1);
    chk("mid_rst_valid", {31'd0, acc_valid_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, res_ready_o}, 32'd1);
    chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    apb_rd_chk("post_rst_status", 12'h00C, 32'h0000_000A);
    apb_rd_chk("post_rst_ctrl", 12'h000, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
